seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring (shift-subtract) unsigned divider: the inverse operation of the sequential shift-add multiplier.
//  Pops one {dividend, divisor} operand pair from the upstream operand queue. Computes one quotient bit per cycle.
//  Presents quotient/remainder with a one-cycle result_valid pulse.
//  Sits beside the multiplier behind the same start/ready/empty/flush queue handshake.
// PARAMETERS
//  WIDTH   8                     operand, quotient and remainder width in bits (>=2)
//  CNT_W   $clog2(WIDTH+1)       iteration counter width; derived, not overridden
// PORTS
//  clk           in   1      rising-edge clock, single clock domain
//  reset         in   1      synchronous, active-high reset
//  start         in   1      request to begin a division
//  empty         in   1      operand queue empty
//  dividend      in   WIDTH  head-of-queue dividend, sampled when load_words=1
//  divisor       in   WIDTH  head-of-queue divisor, sampled when load_words=1
//  load_words    out  1      combinational pop strobe to the operand queue
//  ready         out  1      block is idle or done and can accept start
//  flush         out  1      combinational; start arrived while queue empty
//  quotient      out  WIDTH  registered quotient
//  remainder     out  WIDTH  registered remainder
//  result_valid  out  1      one-cycle pulse when quotient/remainder are final
//  div_by_zero   out  1      registered; set with result when divisor==0
// BEHAVIOUR
//  Reset: state=IDLE; quotient, remainder, counter = 0; result_valid=0; div_by_zero=0.
//   Reset is synchronous and overrides everything, including mid-RUN; the partial result is discarded.
//  States:
//   IDLE = S_IDLE
//   RUN  = S_RUN
//   DONE = S_DONE
//  Outputs in IDLE and DONE:
//   ready=1
//   load_words = start & ~empty
//   flush      = start &  empty
//  Outputs in RUN: ready=0, load_words=0, flush=0. start is ignored in RUN.
//  IDLE/DONE, start & ~empty:
//   Latch operands; rem_acc=0; quo_acc=dividend; cnt=0; clear div_by_zero.
//   If divisor==0, next state is DONE: quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, result_valid=1 next cycle.
//   Otherwise next state is RUN.
//  IDLE/DONE, start & empty: next state DONE; quotient/remainder unchanged; result_valid stays 0.
//  IDLE/DONE, no start: IDLE stays IDLE; DONE returns to IDLE.
//  RUN, per cycle:
//   {r,q} = {rem_acc,quo_acc} << 1   (r is WIDTH+1 bits wide)
//   if r >= divisor: rem_acc = r - divisor and q[0]=1; else rem_acc = r[WIDTH-1:0] and q[0]=0
//   cnt++
//   When cnt==WIDTH-1 this cycle, go to DONE and register quotient/remainder. result_valid=1 for exactly that DONE entry cycle.
//  Latency: start accepted at edge T -> result_valid high in cycle T+WIDTH (WIDTH RUN cycles); div_by_zero path -> T+1.
//  Throughput: start held high in DONE with non-empty queue re-launches in the same cycle as result_valid (back-to-back).
//  Arithmetic: unsigned only. The trial subtract uses WIDTH+1 bits so no overflow is possible.
//   Invariant: remainder < divisor whenever div_by_zero=0.
//  quotient/remainder hold their value until the next valid result or reset.
// STRUCTURE
//  Package div_pkg holds:
//   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t
//   localparam helper for the CNT_W calculation
//  Sub-module div_datapath holds rem_acc/quo_acc, the shift-subtract step and the counter. Its controls are load, step and count_done.
//  The top level holds the FSM and output registers only.
// TESTING (WIDTH=8)
//  100/7, start with queue non-empty -> load_words pulse 1 cycle; result_valid 8 cycles later; q=14, r=2, dbz=0
//  5/9, then 255/1 back-to-back (start held in DONE) -> q=0, r=5; next q=255, r=0; no idle cycle between
//  200/0 -> 1 cycle later result_valid=1, dbz=1, q=0xFF, r=200
//  start with empty=1 -> flush=1 same cycle, load_words=0, result_valid never asserted, previous q/r retained
//  reset asserted at RUN cycle 4 of 77/3 -> next cycle state IDLE, ready=1, q=r=0, no result_valid
//  start toggled during RUN -> ignored; load_words stays 0 until DONE

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH so the iteration index never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Shift-subtract datapath: partial remainder, quotient shift register,
// latched divisor and iteration counter.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] step_quo,
  output logic [WIDTH-1:0] step_rem,
  output logic             count_done
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;

  // Trial value is one bit wider than the operands so the compare never overflows.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    step_quo = {quo_q[WIDTH-2:0], 1'b0};
    step_rem = trial[WIDTH-1:0];
    if (trial >= {1'b0, dvs_q}) begin
      step_rem    = WIDTH'(trial - {1'b0, dvs_q});
      step_quo[0] = 1'b1;
    end
    count_done = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: queue handshake FSM plus result registers.
//   S_IDLE | waiting for start; can pop operands
//   S_RUN  | one quotient bit per cycle, start ignored
//   S_DONE | result cycle; can relaunch back-to-back
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             empty,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             load_words,
  output logic             ready,
  output logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;
  logic             dp_load, dp_step, count_done;
  logic [WIDTH-1:0] step_quo, step_rem;

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (dp_load),
    .step       (dp_step),
    .dividend   (dividend),
    .divisor    (divisor),
    .step_quo   (step_quo),
    .step_rem   (step_rem),
    .count_done (count_done)
  );

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    valid_d    = 1'b0;
    dbz_d      = dbz_q;
    ready      = 1'b0;
    load_words = 1'b0;
    flush      = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        ready      = 1'b1;
        load_words = start & ~empty;
        flush      = start & empty;
        dp_load    = start & ~empty;
        if (start && !empty) begin
          dbz_d = 1'b0;
          // Zero divisor skips iteration and reports a saturated quotient.
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (start) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        dp_step = 1'b1;
        if (count_done) begin
          state_d = S_DONE;
          quo_d   = step_quo;
          rem_d   = step_rem;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient     = quo_q;
  assign remainder    = rem_q;
  assign result_valid = valid_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, empty;
  logic [W-1:0] dividend, divisor;
  logic         load_words, ready, flush, result_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .empty        (empty),
    .dividend     (dividend),
    .divisor      (divisor),
    .load_words   (load_words),
    .ready        (ready),
    .flush        (flush),
    .quotient     (quotient),
    .remainder    (remainder),
    .result_valid (result_valid),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'(result_valid), 0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Called at a negedge; drives a start with a non-empty queue.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    start    = 1'b1;
    empty    = 1'b0;
    dividend = a;
    divisor  = b;
    #1;
    check("load_words_on_start", 32'(load_words), 1);
    check("flush_on_start", 32'(flush), 0);
    if (push) begin
      if (b == '0) begin
        e.q = '1; e.r = a; e.dbz = 1'b1;
      end else begin
        e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_rv(output int k);
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end while (!result_valid && k < 40);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    launch(a, b, 1'b1);
    wait_rv(k);
    check("latency", 32'(k), (b == '0) ? 1 : W + 1);
  endtask

  initial begin
    int k;
    int rv_seen;
    reset = 1'b1; start = 1'b0; empty = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_quotient", 32'(quotient), 0);
    check("reset_remainder", 32'(remainder), 0);
    check("reset_result_valid", 32'(result_valid), 0);
    check("reset_div_by_zero", 32'(div_by_zero), 0);
    check("reset_ready", 32'(ready), 1);
    reset = 1'b0;
    @(negedge clk);

    run_div(8'd100, 8'd7);
    @(negedge clk);
    run_div(8'd200, 8'd0);
    @(negedge clk);

    // Back-to-back: relaunch in the result cycle.
    launch(8'd5, 8'd9, 1'b1);
    wait_rv(k);
    check("latency_b2b_first", 32'(k), W + 1);
    launch(8'd255, 8'd1, 1'b1);
    check("b2b_ready", 32'(ready), 1);
    wait_rv(k);
    check("latency_b2b_second", 32'(k), W + 1);

    // Start with empty queue.
    @(negedge clk);
    start = 1'b1; empty = 1'b1;
    #1;
    check("flush_empty", 32'(flush), 1);
    check("load_words_empty", 32'(load_words), 0);
    @(negedge clk);
    start = 1'b0; empty = 1'b0;
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("flush_no_result", 32'(rv_seen), 0);
    check("flush_keeps_quotient", 32'(quotient), 255);
    check("flush_keeps_remainder", 32'(remainder), 0);
    check("idle_ready", 32'(ready), 1);

    run_div(8'd255, 8'd255);
    @(negedge clk);
    run_div(8'd0, 8'd5);
    @(negedge clk);
    run_div(8'd7, 8'd200);
    @(negedge clk);
    run_div(8'd255, 8'd2);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run_div(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(negedge clk);
    end

    // start toggling during RUN is ignored.
    launch(8'd200, 8'd13, 1'b1);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = i[0];
      #1;
      check("run_load_words", 32'(load_words), 0);
      check("run_ready", 32'(ready), 0);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check("toggle_result_valid", 32'(result_valid), 1);
    @(negedge clk);

    // Reset in the middle of 77/3 discards the partial result.
    launch(8'd77, 8'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrun_reset_ready", 32'(ready), 1);
    check("midrun_reset_quotient", 32'(quotient), 0);
    check("midrun_reset_remainder", 32'(remainder), 0);
    check("midrun_reset_valid", 32'(result_valid), 0);
    reset = 1'b0;
    rv_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("midrun_no_result", 32'(rv_seen), 0);

    run_div(8'd77, 8'd3);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
